// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences the shared datapath one instruction
// at a time, stalls on the memory-ready handshake, counts retired
// instructions and flags illegal encodings.
module multi_cycle_ctrl #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   pc_en,
    output logic                   i_or_d,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   ir_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [1:0]             pc_source,
    output logic [3:0]             alu_ctrl,
    output logic [3:0]             state,
    output logic                   illegal_op,
    output logic [COUNT_WIDTH-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] op_q;
    logic [5:0] funct_q;
    logic       pc_write;
    logic       pc_write_cond;
    logic       retire;

    function automatic logic funct_legal(input logic [5:0] f);
        return (f == FN_ADD) || (f == FN_SUB) || (f == FN_AND) ||
               (f == FN_OR)  || (f == FN_NOR) || (f == FN_SLT);
    endfunction

    // State register; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) cur_state <= S_FETCH;
        else        cur_state <= nxt_state;
    end

    // Capture the instruction fields at the end of DECODE for later states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= '0;
            funct_q <= '0;
        end else if (cur_state == S_DECODE) begin
            op_q    <= opcode;
            funct_q <= funct;
        end
    end

    // An instruction retires on the edge that returns a completed instruction to FETCH.
    assign retire = (cur_state == S_MEM_WB) || (cur_state == S_R_WB) ||
                    (cur_state == S_BRANCH) || (cur_state == S_JUMP) ||
                    (cur_state == S_ADDI_WB) ||
                    ((cur_state == S_MEM_WRITE) && mem_ready);

    // Retired-instruction counter, wraps modulo 2^COUNT_WIDTH.
    always_ff @(posedge clk) begin
        if (!rst_n)      instr_count <= '0;
        else if (retire) instr_count <= instr_count + COUNT_WIDTH'(1);
    end

    // Next-state decode.
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        nxt_state = S_FETCH;
        case (cur_state)
            S_FETCH:     nxt_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     nxt_state = funct_legal(funct) ? S_EXECUTE : S_ILLEGAL;
                    OP_LW, OP_SW: nxt_state = S_MEM_ADDR;
                    OP_BEQ:       nxt_state = S_BRANCH;
                    OP_J:         nxt_state = S_JUMP;
                    OP_ADDI:      nxt_state = S_ADDI_EXEC;
                    default:      nxt_state = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  nxt_state = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  nxt_state = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: nxt_state = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   nxt_state = S_R_WB;
            S_ADDI_EXEC: nxt_state = S_ADDI_WB;
            default:     nxt_state = S_FETCH;
        endcase
    end

    // Control strobes decoded from the current state; all forced low during reset.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_ctrl      = ALU_AND;
        illegal_op    = 1'b0;
        if (rst_n) begin
            case (cur_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    alu_ctrl  = ALU_ADD;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_ctrl  = ALU_ADD;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    case (funct_q)
                        FN_ADD:  alu_ctrl = ALU_ADD;
                        FN_SUB:  alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_NOR:  alu_ctrl = ALU_NOR;
                        FN_SLT:  alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_ctrl      = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                end
                S_ADDI_WB: reg_write  = 1'b1;
                S_ILLEGAL: illegal_op = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = cur_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: randomized instruction streams
// checked cycle by cycle against an instruction-level reference model.
module tb_multi_cycle_ctrl;

    logic clk;
    logic rst_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic zero;
    logic mem_ready;

    logic pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, pc_source;
    logic [3:0] alu_ctrl, state;
    logic [31:0] instr_count;

    logic w_pc_en, w_i_or_d, w_mem_read, w_mem_write, w_ir_write, w_reg_dst, w_mem_to_reg, w_reg_write, w_alu_src_a, w_illegal_op;
    logic [1:0] w_alu_src_b, w_pc_source;
    logic [3:0] w_alu_ctrl, w_state;
    logic [3:0] w_instr_count;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_count = '0;

    // Per-cycle expected/observed trace of the most recent instruction.
    int          exp_st[$];
    int          obs_st[$];
    logic [17:0] exp_cv[$];
    logic [17:0] obs_cv[$];

    logic [17:0] obs_ctrl;
    assign obs_ctrl = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                       reg_write, alu_src_a, alu_src_b, pc_source, alu_ctrl, illegal_op};

    multi_cycle_ctrl #(.COUNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_ctrl(alu_ctrl), .state(state),
        .illegal_op(illegal_op), .instr_count(instr_count)
    );

    multi_cycle_ctrl #(.COUNT_WIDTH(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(w_pc_en), .i_or_d(w_i_or_d), .mem_read(w_mem_read), .mem_write(w_mem_write), .ir_write(w_ir_write),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .reg_write(w_reg_write), .alu_src_a(w_alu_src_a),
        .alu_src_b(w_alu_src_b), .pc_source(w_pc_source), .alu_ctrl(w_alu_ctrl), .state(w_state),
        .illegal_op(w_illegal_op), .instr_count(w_instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h27:   return 4'b1100;
            6'h2A:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Expected strobes for one step of an instruction, straight from the step table.
    function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic z, input logic [5:0] fn);
        logic pe, iod, mrd, mw, irw, rd, m2r, rw, sa, ill;
        logic [1:0] sb, ps;
        logic [3:0] ac;
        {pe, iod, mrd, mw, irw, rd, m2r, rw, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ac = 4'b0000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; ac = 4'b0010; pe = mr; irw = mr; end
            1:  begin sb = 2'b11; ac = 4'b0010; end
            2:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin sa = 1; ac = alu_of(fn); end
            7:  begin rw = 1; rd = 1; end
            8:  begin sa = 1; ac = 4'b0110; ps = 2'b01; pe = z; end
            9:  begin pe = 1; ps = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ac = 4'b0010; end
            11: rw = 1;
            12: ill = 1;
            default: ;
        endcase
        return {pe, iod, mrd, mw, irw, rd, m2r, rw, sa, sb, ps, ac, ill};
    endfunction

    // Runs one instruction from FETCH: builds the expected step list from the
    // instruction rules, drives it, and records expected/observed per cycle.
    // Entered and left just after a rising edge.
    task automatic drive_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input logic zv);
        int   st_q[$];
        logic mr_q[$];
        bit   retires;
        exp_st.delete(); obs_st.delete(); exp_cv.delete(); obs_cv.delete();
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        retires = 1'b1;
        if (op == 6'h00 && (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A})) begin
            st_q.push_back(6); mr_q.push_back(1'($urandom));
            st_q.push_back(7); mr_q.push_back(1'($urandom));
        end else if (op == 6'h23) begin
            st_q.push_back(2); mr_q.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
            st_q.push_back(3); mr_q.push_back(1'b1);
            st_q.push_back(4); mr_q.push_back(1'($urandom));
        end else if (op == 6'h2B) begin
            st_q.push_back(2); mr_q.push_back(1'($urandom));
            for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
            st_q.push_back(5); mr_q.push_back(1'b1);
        end else if (op == 6'h04) begin
            st_q.push_back(8); mr_q.push_back(1'($urandom));
        end else if (op == 6'h02) begin
            st_q.push_back(9); mr_q.push_back(1'($urandom));
        end else if (op == 6'h08) begin
            st_q.push_back(10); mr_q.push_back(1'($urandom));
            st_q.push_back(11); mr_q.push_back(1'($urandom));
        end else begin
            st_q.push_back(12); mr_q.push_back(1'($urandom));
            retires = 1'b0;
        end
        for (int k = 0; k < st_q.size(); k++) begin
            mem_ready = mr_q[k];
            zero = (st_q[k] == 8) ? zv : 1'($urandom);
            if (st_q[k] == 1) begin opcode = op; funct = fn; end
            else begin opcode = 6'($urandom); funct = 6'($urandom); end
            @(negedge clk);
            exp_st.push_back(st_q[k]);
            exp_cv.push_back(exp_ctrl(st_q[k], mr_q[k], zero, fn));
            obs_st.push_back(int'(state));
            obs_cv.push_back(obs_ctrl);
            @(posedge clk); #1;
        end
        if (retires) model_count = model_count + 32'd1;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; opcode = 6'h23; funct = 6'h20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctrl !== 18'd0) begin errors++; $display("FAIL reset_ctrl cyc%0d: got %h want 0", i, obs_ctrl); end
        end
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
        checks++;
        if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        checks++;
        if (w_instr_count !== 4'd0) begin errors++; $display("FAIL reset_count_w: got %0d want 0", w_instr_count); end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_ready = 1'b0; model_count = '0;
    endtask

    task automatic test_lw();
        drive_instr(6'h23, 6'($urandom), 2, 1, 1'b0);
        checks++;
        if (exp_st.size() != 8) begin errors++; $display("FAIL lw_len: got %0d want 8", exp_st.size()); end
        for (int k = 0; k < exp_st.size(); k++) begin
            checks++;
            if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL lw_state[%0d]: got %0d want %0d", k, obs_st[k], exp_st[k]); end
            checks++;
            if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL lw_ctrl[%0d]: got %h want %h", k, obs_cv[k], exp_cv[k]); end
        end
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d want 0", state); end
        checks++;
        if (instr_count !== model_count) begin errors++; $display("FAIL lw_count: got %0d want %0d", instr_count, model_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_rtype();
        drive_instr(6'h00, 6'h22, 0, 0, 1'b0);
        for (int k = 0; k < exp_st.size(); k++) begin
            checks++;
            if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL sub_state[%0d]: got %0d want %0d", k, obs_st[k], exp_st[k]); end
            checks++;
            if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL sub_ctrl[%0d]: got %h want %h", k, obs_cv[k], exp_cv[k]); end
        end
        checks++;
        if (instr_count !== model_count) begin errors++; $display("FAIL sub_count: got %0d want %0d", instr_count, model_count); end
    endtask

    task automatic test_branch();
        for (int z = 1; z >= 0; z--) begin
            drive_instr(6'h04, 6'($urandom), int'($urandom_range(0, 2)), 0, 1'(z));
            for (int k = 0; k < exp_st.size(); k++) begin
                checks++;
                if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL beq%0d_state[%0d]: got %0d want %0d", z, k, obs_st[k], exp_st[k]); end
                checks++;
                if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL beq%0d_ctrl[%0d]: got %h want %h", z, k, obs_cv[k], exp_cv[k]); end
            end
            checks++;
            if (instr_count !== model_count) begin errors++; $display("FAIL beq%0d_count: got %0d want %0d", z, instr_count, model_count); end
        end
    endtask

    task automatic test_illegal();
        logic [5:0] ops[2] = '{6'h3F, 6'h00};
        logic [5:0] fns[2] = '{6'h20, 6'h01};
        for (int t = 0; t < 2; t++) begin
            drive_instr(ops[t], fns[t], 0, 0, 1'b0);
            for (int k = 0; k < exp_st.size(); k++) begin
                checks++;
                if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL ill%0d_state[%0d]: got %0d want %0d", t, k, obs_st[k], exp_st[k]); end
                checks++;
                if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL ill%0d_ctrl[%0d]: got %h want %h", t, k, obs_cv[k], exp_cv[k]); end
            end
            @(negedge clk);
            checks++;
            if (state !== 4'd0 || illegal_op !== 1'b0) begin
                errors++; $display("FAIL ill%0d_after: state %0d illegal_op %b want 0/0", t, state, illegal_op);
            end
            checks++;
            if (instr_count !== model_count) begin errors++; $display("FAIL ill%0d_count: got %0d want %0d", t, instr_count, model_count); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [5:0] op_tab[7] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08, 6'h00};
        logic [5:0] fn_tab[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op, fn;
            op = (($urandom % 8) == 0) ? 6'($urandom) : op_tab[$urandom % 7];
            fn = (($urandom % 6) == 0) ? 6'($urandom) : fn_tab[$urandom % 6];
            drive_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
            for (int k = 0; k < exp_st.size(); k++) begin
                checks++;
                if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL rnd%0d op%h fn%h state[%0d]: got %0d want %0d", n, op, fn, k, obs_st[k], exp_st[k]); end
                checks++;
                if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL rnd%0d op%h fn%h ctrl[%0d]: got %h want %h", n, op, fn, k, obs_cv[k], exp_cv[k]); end
            end
            checks++;
            if (instr_count !== model_count) begin errors++; $display("FAIL rnd%0d_count: got %0d want %0d", n, instr_count, model_count); end
            checks++;
            if (w_instr_count !== model_count[3:0]) begin errors++; $display("FAIL rnd%0d_count_w: got %0d want %0d", n, w_instr_count, model_count[3:0]); end
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL rmid_fetch: got %0d want 0", state); end
        @(posedge clk); #1;
        opcode = 6'h2B; mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd1) begin errors++; $display("FAIL rmid_decode: got %0d want 1", state); end
        @(posedge clk); #1;
        opcode = 6'($urandom);
        @(negedge clk);
        checks++;
        if (state !== 4'd2) begin errors++; $display("FAIL rmid_addr: got %0d want 2", state); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (state !== 4'd5 || mem_write !== 1'b1) begin errors++; $display("FAIL rmid_wait: state %0d mem_write %b want 5/1", state, mem_write); end
        @(posedge clk); #1;
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_write !== 1'b0 || obs_ctrl !== 18'd0) begin errors++; $display("FAIL rmid_abort: mem_write %b ctrl %h want 0/0", mem_write, obs_ctrl); end
        @(posedge clk); #1;
        checks++;
        if (state !== 4'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", state); end
        checks++;
        if (instr_count !== 32'd0 || w_instr_count !== 4'd0) begin errors++; $display("FAIL rmid_count: got %0d/%0d want 0/0", instr_count, w_instr_count); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs_ctrl !== 18'd0) begin errors++; $display("FAIL rmid_hold%0d: got %h want 0", i, obs_ctrl); end
            @(posedge clk); #1;
        end
        rst_n = 1'b1; mem_ready = 1'b0; model_count = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] want;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; model_count = '0;
        for (int n = 1; n <= 17; n++) begin
            drive_instr(6'h02, 6'($urandom), int'($urandom_range(0, 1)), 0, 1'b0);
            for (int k = 0; k < exp_st.size(); k++) begin
                checks++;
                if (obs_st[k] !== exp_st[k]) begin errors++; $display("FAIL j%0d_state[%0d]: got %0d want %0d", n, k, obs_st[k], exp_st[k]); end
                checks++;
                if (obs_cv[k] !== exp_cv[k]) begin errors++; $display("FAIL j%0d_ctrl[%0d]: got %h want %h", n, k, obs_cv[k], exp_cv[k]); end
            end
            if (n >= 15) begin
                want = (n == 15) ? 4'd15 : (n == 16) ? 4'd0 : 4'd1;
                checks++;
                if (w_instr_count !== want) begin errors++; $display("FAIL wrap_after_%0d: got %0d want %0d", n, w_instr_count, want); end
            end
        end
        checks++;
        if (instr_count !== 32'd17) begin errors++; $display("FAIL wrap_count32: got %0d want 17", instr_count); end
    endtask

    initial begin
        rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_illegal();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
